conv3x3_engine: RTL and testbench
=================================

# conv3x3_engine

Pipelined 3x3 convolution stage directly downstream of the 66x66 window memory. Drives the memory's read strobe, consumes the nine 8-bit window pixels it returns, applies a programmable signed 3x3 kernel with right-shift normalisation and saturation, and returns one 8-bit result pixel plus a write strobe to the memory's write port. One frame is 64x64 windows, started by a single pulse and reported complete by a `done` pulse.

## Interface
Parameters:
- `IMG_W`, 64: windows per row.
- `IMG_H`, 64: window rows per frame.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; shared with the window memory.
- `start`  in  1  frame start pulse; honoured only in IDLE.
- `coef_we`  in  1  coefficient register write enable; honoured only in IDLE.
- `coef_addr`  in  4  0..8 selects kernel tap k00..k22, row-major; 9 selects the shift register; 10..15 ignored.
- `coef_data`  in  8  signed tap value, or shift amount in bits [3:0].
- `pixelr1`..`pixelr9`  in  8 each  window pixels from memory, row-major, valid one cycle after `rd`.
- `rd`  out  1  window read request to memory.
- `pixelw`  out  8  result pixel.
- `wr`  out  1  result write strobe to memory.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> DRAIN when the window counter issues its IMG_W*IMG_H-th `rd`; DRAIN -> DONE when the pipeline is empty; DONE -> IDLE unconditionally after one cycle.
- RUN: `rd` held high every cycle; 12-bit window counter increments per `rd`.
- Internal valid shift register tracks `rd` through memory latency (1) and three pipeline stages.
- Stage 1: pixel zero-extended to 9-bit signed, times 8-bit signed tap -> 17-bit signed product, nine registered.
- Stage 2: three row sums, 19-bit signed, registered.
- Stage 3: total, 21-bit signed; arithmetic right shift by shift[3:0]; clamp to 0..255; register to `pixelw`, `wr` = delayed valid.
- Reset values: taps all 0 except k11 = 1, shift = 0 (identity kernel); `rd`, `wr`, `busy`, `done` 0; `pixelw` 0; counters 0; FSM IDLE.
- `start` in RUN/DRAIN/DONE ignored. `coef_we` outside IDLE ignored. Simultaneous `start` and `coef_we` in IDLE: write takes effect, frame uses the new value (write lands before the first stage-1 product).
- `pixelw` holds its last value when `wr` is low.
- `rst_n` asserted mid-frame: all state, pipeline and coefficients return to reset values immediately; no `done`.

## Timing
- `rd` first high the cycle after `start` is sampled.
- `wr` for a window is high exactly 4 cycles after the `rd` that requested it; frame produces exactly 4096 contiguous `wr` cycles.
- `done` high the cycle after the last `wr`; `busy` falls in that same cycle.
- Back-to-back frames: `start` accepted the cycle after `done`.

## Configuration
- `CONV3X3_ABS_EN` defined: negative stage-3 results are replaced by their magnitude before shift/clamp (edge-detect magnitude).
- Undefined: negative results clamp to 0.

## Structure
- Shared package `conv_pkg`: `PIX_W`=8, `COEF_W`=8, `PROD_W`=17, `ACC_W`=21, `SHIFT_W`=4, FSM state enum type, tap address constants (`ADDR_SHIFT`=9).
- One sub-module: `conv_mac_pipe` (stages 1-3 plus clamp, valid in/out); FSM, counter and coefficient registers stay in the top.

## Test plan
- After reset, `start`, all pixels 100 -> 4096 `wr` pulses, each `pixelw`=100, first `wr` 5 cycles after `start` edge, `done` one cycle after last `wr`.
- Taps all 1, shift 3, all pixels 80 -> sum 720, `pixelw`=90.
- Taps all 127, shift 0, all pixels 255 -> sum 291465, no wrap, `pixelw`=255.
- Laplacian k11=8 others -1, center 0 others 255 -> sum -2040: `pixelw`=0 without `CONV3X3_ABS_EN`, 255 with it.
- `coef_we` and `start` pulsed mid-RUN -> no tap change, no restart, still exactly 4096 `wr`.
- `rst_n` low at window 1000 -> `rd`, `wr`, `busy` low at once, no `done`; next frame with no writes behaves as identity kernel.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// Holds datapath widths, the frame FSM state type, coefficient
// addressing and the output clamp helper.
package conv_pkg;

  localparam int PIX_W    = 8;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 17;
  localparam int ROW_W    = 19;
  localparam int ACC_W    = 21;
  localparam int SHIFT_W  = 4;
  localparam int NUM_TAPS = 9;
  localparam int CNT_W    = 12;

  localparam logic [3:0] ADDR_K00   = 4'd0;
  localparam logic [3:0] ADDR_K11   = 4'd4;
  localparam logic [3:0] ADDR_K22   = 4'd8;
  localparam logic [3:0] ADDR_SHIFT = 4'd9;

  // Identity kernel: only the centre tap (k11) is 1.
  localparam logic [NUM_TAPS*COEF_W-1:0] TAPS_IDENTITY =
    {{4{8'h00}}, 8'h01, {4{8'h00}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Saturate a signed accumulator into the 0..255 pixel range.
  function automatic logic [PIX_W-1:0] clamp_pixel(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1])
      return '0;
    else if (|v[ACC_W-2:PIX_W])
      return '1;
    else
      return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// Three-stage multiply / row-sum / total pipeline with shift and clamp.
// Optional build macro CONV3X3_ABS_EN: negative totals are replaced by
// their magnitude before shift and clamp (edge-detect magnitude).
module conv_mac_pipe
  import conv_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [NUM_TAPS*PIX_W-1:0]    pixels,
  input  logic [NUM_TAPS*COEF_W-1:0]   taps,
  input  logic [SHIFT_W-1:0]           shift,
  output logic [PIX_W-1:0]             pixel_out,
  output logic                         out_valid,
  output logic                         active
);

  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [ROW_W-1:0]  row_d  [3];
  logic signed [ROW_W-1:0]  row_q  [3];
  logic signed [ACC_W-1:0]  total;
  logic signed [ACC_W-1:0]  magnitude;
  logic signed [ACC_W-1:0]  shifted;
  logic [PIX_W-1:0]         pixel_d, pixel_q;
  logic                     s1_valid_q, s2_valid_q, out_valid_q;

  // Stage 1: unsigned pixel (zero-extended) times signed tap for all nine taps.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, pixels[i*PIX_W +: PIX_W]}))
                * PROD_W'($signed(taps[i*COEF_W +: COEF_W]));
    end
  end

  // Stage 2: one sum per kernel row.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
    end
  end

  // Stage 3: total, optional magnitude, normalising shift and clamp; hold when idle.
  always_comb begin
    total = ACC_W'(row_q[0]) + ACC_W'(row_q[1]) + ACC_W'(row_q[2]);
`ifdef CONV3X3_ABS_EN
    magnitude = total[ACC_W-1] ? -total : total;
`else
    magnitude = total;
`endif
    shifted = magnitude >>> shift;
    pixel_d = s2_valid_q ? clamp_pixel(shifted) : pixel_q;
  end

  // Pipeline registers and the valid bits that travel alongside them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= '0;
      for (int r = 0; r < 3; r++) row_q[r] <= '0;
      pixel_q     <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= prod_d[i];
      for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
      pixel_q     <= pixel_d;
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
    end
  end

  assign pixel_out = pixel_q;
  assign out_valid = out_valid_q;
  assign active    = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: frame FSM, window read counter and kernel
// registers, feeding the conv_mac_pipe datapath. The optional
// CONV3X3_ABS_EN macro is consumed inside conv_mac_pipe.
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                coef_we,
  input  logic [3:0]          coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  input  logic [PIX_W-1:0]    pixelr1,
  input  logic [PIX_W-1:0]    pixelr2,
  input  logic [PIX_W-1:0]    pixelr3,
  input  logic [PIX_W-1:0]    pixelr4,
  input  logic [PIX_W-1:0]    pixelr5,
  input  logic [PIX_W-1:0]    pixelr6,
  input  logic [PIX_W-1:0]    pixelr7,
  input  logic [PIX_W-1:0]    pixelr8,
  input  logic [PIX_W-1:0]    pixelr9,
  output logic                rd,
  output logic [PIX_W-1:0]    pixelw,
  output logic                wr,
  output logic                busy,
  output logic                done
);

  localparam int               TOTAL    = IMG_W * IMG_H;
  localparam logic [CNT_W-1:0] LAST_WIN = CNT_W'(TOTAL - 1);

  state_e                       state_q;
  logic                         rd_q, busy_q, done_q, mem_valid_q;
  logic [CNT_W-1:0]             win_cnt_q;
  logic [NUM_TAPS*COEF_W-1:0]   taps_d, taps_q;
  logic [SHIFT_W-1:0]           shift_d, shift_q;
  logic                         pipe_active;

  // Kernel and shift updates are accepted only while idle.
  always_comb begin
    taps_d  = taps_q;
    shift_d = shift_q;
    if (coef_we && state_q == ST_IDLE) begin
      if (coef_addr == ADDR_SHIFT) begin
        shift_d = coef_data[SHIFT_W-1:0];
      end else begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          if (coef_addr == 4'(i)) taps_d[i*COEF_W +: COEF_W] = coef_data;
        end
      end
    end
  end

  // Kernel registers come out of reset as the identity kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q  <= TAPS_IDENTITY;
      shift_q <= '0;
    end else begin
      taps_q  <= taps_d;
      shift_q <= shift_d;
    end
  end

  // Frame sequencer: issue one read per cycle, then wait for the pipe to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RUN;
            rd_q      <= 1'b1;
            busy_q    <= 1'b1;
            win_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (win_cnt_q == LAST_WIN) begin
            win_cnt_q <= '0;
            rd_q      <= 1'b0;
            state_q   <= ST_DRAIN;
          end else begin
            win_cnt_q <= win_cnt_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!mem_valid_q && !pipe_active) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Marks the cycle in which the memory presents the pixels for an issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_valid_q <= 1'b0;
    else        mem_valid_q <= rd_q;
  end

  conv_mac_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (mem_valid_q),
    .pixels    ({pixelr9, pixelr8, pixelr7, pixelr6, pixelr5,
                 pixelr4, pixelr3, pixelr2, pixelr1}),
    .taps      (taps_q),
    .shift     (shift_q),
    .pixel_out (pixelw),
    .out_valid (wr),
    .active    (pipe_active)
  );

  assign rd   = rd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed testbench for conv3x3_engine: whole frames with constant
// windows and hand-computed result pixels, plus mid-frame abuse and reset.
module tb_conv3x3_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       coef_we;
  logic [3:0] coef_addr;
  logic [7:0] coef_data;
  logic [7:0] pix [9];
  logic       rd, wr, busy, done;
  logic [7:0] pixelw;

  int total_checks = 0;
  int bad_checks   = 0;

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  conv3x3_engine #(.IMG_W(64), .IMG_H(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .pixelr1   (pix[0]),
    .pixelr2   (pix[1]),
    .pixelr3   (pix[2]),
    .pixelr4   (pix[3]),
    .pixelr5   (pix[4]),
    .pixelr6   (pix[5]),
    .pixelr7   (pix[6]),
    .pixelr8   (pix[7]),
    .pixelr9   (pix[8]),
    .rd        (rd),
    .pixelw    (pixelw),
    .wr        (wr),
    .busy      (busy),
    .done      (done)
  );

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) else begin
      bad_checks++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Single coefficient write; entered and left on a falling edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic setAllTaps(input logic [7:0] value);
    for (int i = 0; i < 9; i++) applyStimulus(4'(i), value);
  endtask

  task automatic setPixels(input logic [7:0] outer, input logic [7:0] centre);
    for (int i = 0; i < 9; i++) pix[i] = (i == 4) ? centre : outer;
  endtask

  // Run a full frame from a falling edge, checking every result and the
  // frame timing; optionally writes a coefficient together with start and
  // pokes start/coef_we at cycle poke_cyc while running.
  task automatic runFrame(input string tag, input logic [7:0] exp_pix,
                          input bit we_with_start, input logic [3:0] wa,
                          input logic [7:0] wd, input int poke_cyc);
    int cyc, rd_cnt, wr_cnt, first_wr, last_wr, done_cyc;
    logic busy_at_last_wr;
    start     = 1'b1;
    coef_we   = we_with_start;
    coef_addr = wa;
    coef_data = wd;
    @(negedge clk);
    start   = 1'b0;
    coef_we = 1'b0;
    cyc = 1; rd_cnt = 0; wr_cnt = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
    busy_at_last_wr = 1'b0;
    checkOutput({tag, " rd_first"}, 32'(rd), 32'd1);
    checkOutput({tag, " busy_run"}, 32'(busy), 32'd1);
    while (cyc < 6000 && done_cyc < 0) begin
      if (rd) rd_cnt++;
      if (wr) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
        busy_at_last_wr = busy;
        checkOutput({tag, " pixelw"}, 32'(pixelw), 32'(exp_pix));
      end
      if (done) begin
        done_cyc = cyc;
        checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
      end else begin
        if (cyc == poke_cyc) begin
          start = 1'b1; coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'd0;
        end else if (cyc == poke_cyc + 1) begin
          start = 1'b0; coef_we = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
    checkOutput({tag, " rd_count"}, 32'(rd_cnt), 32'd4096);
    checkOutput({tag, " wr_count"}, 32'(wr_cnt), 32'd4096);
    checkOutput({tag, " first_wr_cycle"}, 32'(first_wr), 32'd5);
    checkOutput({tag, " wr_contiguous"}, 32'(last_wr - first_wr + 1), 32'd4096);
    checkOutput({tag, " done_after_last_wr"}, 32'(done_cyc), 32'(last_wr + 1));
    checkOutput({tag, " busy_at_last_wr"}, 32'(busy_at_last_wr), 32'd1);
    @(negedge clk);
    checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
    checkOutput({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Directed test sequence.
  initial begin
    int rd_cnt;
    int n;
    logic [7:0] lap_expected;

    rst_n = 1'b0; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    setPixels(8'd0, 8'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset rd", 32'(rd), 32'd0);
    checkOutput("reset wr", 32'(wr), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset pixelw", 32'(pixelw), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] identity kernel, pixels 100, two frames back to back");
    setPixels(8'd100, 8'd100);
    runFrame("ident_a", 8'd100, 1'b0, 4'd0, 8'd0, -10);
    runFrame("ident_b", 8'd100, 1'b0, 4'd0, 8'd0, -10);

    $display("[TB] taps 1, shift 3 written with start, pixels 80");
    setAllTaps(8'd1);
    setPixels(8'd80, 8'd80);
    runFrame("box_shift3", 8'd90, 1'b1, 4'd9, 8'd3, -10);

    $display("[TB] taps 127, shift 0, pixels 255");
    setAllTaps(8'd127);
    applyStimulus(4'd9, 8'd0);
    setPixels(8'd255, 8'd255);
    runFrame("max_sat", 8'd255, 1'b0, 4'd0, 8'd0, -10);

    $display("[TB] laplacian, centre 0, neighbours 255");
    setAllTaps(8'hFF);
    applyStimulus(4'd4, 8'd8);
    setPixels(8'd255, 8'd0);
`ifdef CONV3X3_ABS_EN
    lap_expected = 8'd255;
`else
    lap_expected = 8'd0;
`endif
    runFrame("laplacian", lap_expected, 1'b0, 4'd0, 8'd0, -10);

    $display("[TB] start and coef_we pulsed mid-run");
    setAllTaps(8'd1);
    applyStimulus(4'd9, 8'd3);
    setPixels(8'd80, 8'd80);
    runFrame("mid_run_poke", 8'd90, 1'b0, 4'd0, 8'd0, 500);

    $display("[TB] reset at window 1000");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_cnt = 0; n = 0;
    while (n < 3000) begin
      if (rd) rd_cnt++;
      if (rd_cnt >= 1000) break;
      @(negedge clk);
      n++;
    end
    checkOutput("rst reached_window_1000", 32'(rd_cnt), 32'd1000);
    checkOutput("rst wr_active_before", 32'(wr), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst rd_low", 32'(rd), 32'd0);
    checkOutput("rst wr_low", 32'(wr), 32'd0);
    checkOutput("rst busy_low", 32'(busy), 32'd0);
    checkOutput("rst pixelw_zero", 32'(pixelw), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post_rst no_done", 32'(done), 32'd0);
    end
    setPixels(8'd100, 8'd100);
    runFrame("post_rst_ident", 8'd100, 1'b0, 4'd0, 8'd0, -10);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
